// File: rtl/board_event_detector.sv
// board_event_detector: debounces each scanned 8x8 occupancy frame and queues
// lift/place events, one per accepted square change, in ascending square order.
module board_event_detector #(
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] sensor_state,
    input  logic        frame_tick,
    input  logic        clr_drop,
    input  logic        ev_ready,
    output logic        ev_valid,
    output logic [6:0]  ev_data,
    output logic [63:0] board_state,
    output logic        busy,
    output logic        frame_drop
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [1:0] DMAX = 2'(DEBOUNCE_FRAMES - 1);
    localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                       state_q, state_d;
    logic [63:0]                  prev_q, prev_d;
    logic [63:0]                  acc_q, acc_d;
    logic [63:0]                  stable_q, stable_d;
    logic [63:0][1:0]             cnt_q, cnt_d, nc;
    logic [5:0]                   idx_q, idx_d;
    logic                         frame_drop_q, frame_drop_d;
    logic [FIFO_DEPTH-1:0][6:0]   mem_q, mem_d;
    logic [AW-1:0]                wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]                  count_q, count_d;
    logic                         diff, full, push, pop;

    assign diff = acc_q[idx_q] ^ stable_q[idx_q];
    // Full uses the registered count, so a same-cycle pop never frees a slot.
    assign full = count_q == FULL;
    assign push = (state_q == SCAN) && diff && !full;
    assign pop  = ev_valid && ev_ready;

    always_comb begin
        for (int i = 0; i < 64; i++)
            nc[i] = (sensor_state[i] == prev_q[i]) ? ((cnt_q[i] == DMAX) ? DMAX : cnt_q[i] + 2'd1) : 2'd0;
    end

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        stable_d     = stable_q;
        idx_d        = idx_q;
        frame_drop_d = frame_drop_q & ~clr_drop;
        if (state_q == IDLE) begin
            if (frame_tick) begin
                prev_d  = sensor_state;
                cnt_d   = nc;
                for (int i = 0; i < 64; i++)
                    acc_d[i] = (nc[i] == DMAX) ? sensor_state[i] : stable_q[i];
                idx_d   = 6'd0;
                state_d = SCAN;
            end
        end else begin
            if (frame_tick)
                frame_drop_d = 1'b1;
            if (push)
                stable_d[idx_q] = acc_q[idx_q];
            if (!diff || !full) begin
                idx_d   = idx_q + 6'd1;
                state_d = (idx_q == 6'd63) ? IDLE : SCAN;
            end
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (push)
            mem_d[wr_q] = {acc_q[idx_q], idx_q};
        wr_d    = wr_q + AW'(push);
        rd_d    = rd_q + AW'(pop);
        count_d = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            prev_q       <= '0;
            cnt_q        <= '0;
            acc_q        <= '0;
            stable_q     <= '0;
            idx_q        <= '0;
            frame_drop_q <= 1'b0;
            mem_q        <= '0;
            wr_q         <= '0;
            rd_q         <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            stable_q     <= stable_d;
            idx_q        <= idx_d;
            frame_drop_q <= frame_drop_d;
            mem_q        <= mem_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            count_q      <= count_d;
        end
    end

    assign ev_valid    = count_q != '0;
    assign ev_data     = mem_q[rd_q];
    assign board_state = stable_q;
    assign busy        = state_q == SCAN;
    assign frame_drop  = frame_drop_q;
endmodule
